// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the 7-segment scan controller
package seg_pkg;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } seg_state_e;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] BLANK_AN = '1;

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - per-slot prescaler; flags end of guard, cycle before slot end, and slot end
module seg_tick_gen #(
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 16
) (
    input  logic clk,
    input  logic rst,
    output logic guard_done,
    output logic slot_pre_end,
    output logic slot_end
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign guard_done   = (cnt == CW'(GUARD - 1));
    assign slot_pre_end = (cnt == CW'(CLK_DIV - 2));
    assign slot_end     = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered multiplexed 7-segment scan controller
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  ready,
    output logic [3:0]            digit_n,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int IW = $clog2(DIGITS);

    seg_state_e                state;
    logic [IW-1:0]             idx;
    logic [IW-1:0]             idx_nxt;
    logic [DIGIT_W*DIGITS-1:0] act_digits;
    logic [DIGIT_W*DIGITS-1:0] act_digits_nxt;
    logic [DIGIT_W*DIGITS-1:0] pend_digits;
    logic [DIGITS-1:0]         act_dp;
    logic [DIGITS-1:0]         pend_dp;
    logic                      pending;
    logic                      commit;
    logic [DIGITS-1:0]         blank;
    logic [DIGITS-1:0]         drive_an;
    logic [DIGIT_W-1:0]        code_nxt;
    logic                      guard_done;
    logic                      slot_pre_end;
    logic                      slot_end;

    seg_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .GUARD   (GUARD)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .guard_done   (guard_done),
        .slot_pre_end (slot_pre_end),
        .slot_end     (slot_end)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic hi_zero;

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        blank   = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hi_zero  = hi_zero && (act_digits[i*DIGIT_W +: DIGIT_W] == '0);
            blank[i] = hi_zero;
        end
    end
`else
    assign blank = '0;
`endif

    // digit_n follows the buffer and index that will be in effect after this edge.
    always_comb begin
        commit         = frame_tick && pending;
        act_digits_nxt = commit ? pend_digits : act_digits;
        idx_nxt        = idx;
        if (state == ST_DRIVE && slot_end) begin
            idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
        code_nxt      = act_digits_nxt[int'(idx_nxt)*DIGIT_W +: DIGIT_W];
        drive_an      = BLANK_AN[DIGITS-1:0];
        drive_an[idx] = blank[idx];
    end

    assign ready = !pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_GUARD;
            idx         <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pending     <= 1'b0;
            an          <= BLANK_AN[DIGITS-1:0];
            dp          <= 1'b1;
            digit_n     <= '0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= (state == ST_DRIVE) && slot_pre_end && (idx == IW'(DIGITS - 1));
            digit_n    <= code_nxt;

            if (commit) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                pending    <= 1'b0;
            end else if (load && !pending) begin
                pend_digits <= value;
                pend_dp     <= dp_mask;
                pending     <= 1'b1;
            end

            case (state)
                ST_GUARD: begin
                    an <= BLANK_AN[DIGITS-1:0];
                    dp <= 1'b1;
                    if (guard_done) begin
                        state <= ST_DRIVE;
                        an    <= drive_an;
                        dp    <= ~act_dp[idx];
                    end
                end
                ST_DRIVE: begin
                    if (slot_end) begin
                        state <= ST_GUARD;
                        an    <= BLANK_AN[DIGITS-1:0];
                        dp    <= 1'b1;
                        idx   <= idx_nxt;
                    end
                end
                default: state <= ST_GUARD;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a time-based display model
module tb_seg_scan_ctrl;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int GUARD   = 2;
    localparam int FRAME   = DIGITS * CLK_DIV;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        ready;
    logic [3:0]  digit_n;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    seg_scan_ctrl #(
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV),
        .GUARD   (GUARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .ready      (ready),
        .digit_n    (digit_n),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycle count since reset, displayed and pending display contents.
    int          t = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [15:0] m_pend_val = '0;
    logic [3:0]  m_pend_dp = '0;
    logic        m_pend = 1'b0;

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            t = 0; m_disp = '0; m_disp_dp = '0; m_pend = 1'b0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && m_pend) begin
                m_disp = m_pend_val; m_disp_dp = m_pend_dp; m_pend = 1'b0;
            end else if (load && !m_pend) begin
                m_pend = 1'b1; m_pend_val = value; m_pend_dp = dp_mask;
            end
            t++;
        end
        @(negedge clk);
    endtask

    // {an, dp, frame_tick, ready, digit code (only meaningful while a digit is lit)}
    function automatic logic [10:0] exp_out();
        int ph = t % CLK_DIV;
        int sl = (t / CLK_DIV) % DIGITS;
        logic [3:0] a = 4'hF;
        logic d = 1'b1;
        logic [3:0] code = 4'h0;
        if (ph >= GUARD) begin
            a = ~(4'b0001 << sl);
            if (LZB && sl > 0 && (m_disp >> (4 * sl)) == 16'h0) a = 4'hF;
            d = ~m_disp_dp[sl];
            code = 4'(m_disp >> (4 * sl));
        end
        return {a, d, (t % FRAME) == FRAME - 1, !m_pend, code};
    endfunction

    function automatic logic [10:0] obs_out();
        return {an, dp, frame_tick, ready, ((t % CLK_DIV) >= GUARD) ? digit_n : 4'h0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if (digit_n !== 4'h0) begin errors++; $display("FAIL reset_digit got %h want 0", digit_n); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int low[DIGITS];
        int ticks = 0;
        foreach (low[i]) low[i] = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL scan t=%0d got %h want %h", t, obs_out(), exp_out()); end
            for (int i = 0; i < DIGITS; i++) if (an[i] === 1'b0) low[i]++;
            if (frame_tick === 1'b1) ticks++;
            tick();
        end
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (low[i] != 2 * (CLK_DIV - GUARD)) begin errors++; $display("FAIL scan_low%0d got %0d want %0d", i, low[i], 2 * (CLK_DIV - GUARD)); end
        end
        checks++; if (ticks != 2) begin errors++; $display("FAIL scan_ticks got %0d want 2", ticks); end
    endtask

    task automatic test_load_commit();
        logic [3:0] want_code[DIGITS];
        logic       want_dp[DIGITS];
        logic       seen[DIGITS];
        int         s;
        load = 1'b1; value = 16'h1234; dp_mask = 4'b0010;
        tick();
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b want 0", ready); end
        for (int c = 0; c < 3 * FRAME; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL load_commit t=%0d got %h want %h", t, obs_out(), exp_out()); end
            if (c == 3) begin load = 1'b1; value = 16'h9999; dp_mask = 4'hF; end
            else load = 1'b0;
            tick();
        end
        load = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL commit_ready got %b want 1", ready); end
        want_code[0] = 4'd4; want_code[1] = 4'd3; want_code[2] = 4'd2; want_code[3] = 4'd1;
        want_dp[0] = 1'b1; want_dp[1] = 1'b0; want_dp[2] = 1'b1; want_dp[3] = 1'b1;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            s = -1;
            for (int i = 0; i < DIGITS; i++) if (an[i] === 1'b0) s = i;
            if (s >= 0 && !seen[s]) begin
                seen[s] = 1'b1;
                checks++;
                if (digit_n !== want_code[s] || dp !== want_dp[s]) begin
                    errors++; $display("FAIL show1234 digit%0d got %h/%b want %h/%b", s, digit_n, dp, want_code[s], want_dp[s]);
                end
            end
            tick();
        end
        for (int i = 0; i < DIGITS; i++) begin
            checks++; if (!seen[i]) begin errors++; $display("FAIL show1234 digit%0d got never-driven want driven", i); end
        end
    endtask

    task automatic test_commit_cycle_load();
        load = 1'b1; value = 16'($urandom); dp_mask = 4'($urandom);
        tick();
        load = 1'b0;
        for (int c = 0; c < FRAME && (t % FRAME) != FRAME - 1; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL cc_wait t=%0d got %h want %h", t, obs_out(), exp_out()); end
            tick();
        end
        checks++;
        if (frame_tick !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL cc_edge got tick=%b ready=%b want tick=1 ready=0", frame_tick, ready); end
        load = 1'b1; value = 16'($urandom); dp_mask = 4'($urandom);
        tick();
        value = 16'($urandom); dp_mask = 4'($urandom);
        tick();
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL cc_accept got ready=%b want 0", ready); end
        for (int c = 0; c < 2 * FRAME; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL cc_run t=%0d got %h want %h", t, obs_out(), exp_out()); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 20 * FRAME; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL random t=%0d got %h want %h", t, obs_out(), exp_out()); end
            load = ($urandom_range(0, 7) == 0);
            value = 16'($urandom); dp_mask = 4'($urandom);
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < FRAME && (t % FRAME) != 0; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL rm_align t=%0d got %h want %h", t, obs_out(), exp_out()); end
            tick();
        end
        load = 1'b1; value = 16'($urandom) | 16'h1111; dp_mask = 4'hF;
        tick();
        load = 1'b0;
        for (int c = 0; c < FRAME && (t % FRAME) != 2 * CLK_DIV + 4; c++) tick();
        checks++; if (ready !== 1'b0 || an !== 4'b1011) begin errors++; $display("FAIL rm_pre got ready=%b an=%b want 0/1011", ready, an); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (an !== 4'hF || ready !== 1'b1 || digit_n !== 4'h0 || dp !== 1'b1 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL rm_post got an=%b ready=%b digit=%h dp=%b want 1111/1/0/1", an, ready, digit_n, dp);
        end
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL rm_run t=%0d got %h want %h", t, obs_out(), exp_out()); end
            tick();
        end
    endtask

    task automatic test_blank();
        int low[DIGITS];
        int want;
        foreach (low[i]) low[i] = 0;
        load = 1'b1; value = 16'h0050; dp_mask = 4'h0;
        tick();
        load = 1'b0;
        for (int c = 0; c < 2 * FRAME - 1; c++) begin
            checks++;
            if (obs_out() !== exp_out()) begin errors++; $display("FAIL blank_run t=%0d got %h want %h", t, obs_out(), exp_out()); end
            if (c >= FRAME - 1) for (int i = 0; i < DIGITS; i++) if (an[i] === 1'b0) low[i]++;
            tick();
        end
        for (int i = 0; i < DIGITS; i++) begin
            want = (LZB && i >= 2) ? 0 : CLK_DIV - GUARD;
            checks++;
            if (low[i] != want) begin errors++; $display("FAIL blank_low%0d got %0d want %0d", i, low[i], want); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_commit();
        test_commit_cycle_load();
        test_random();
        test_reset_mid();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment display bank. Holds a double-buffered set of BCD digits, steps through the digits at a fixed refresh rate and presents one 4-bit code per slot to the existing BCD-to-segment decoder while driving the matching active-low anode. A guard interval between slots keeps all anodes off to prevent ghosting. A load/ready handshake lets the host write a new display value without tearing.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- CLK_DIV, 100000, clk cycles per digit slot, guard included (>= GUARD+2)
- GUARD, 16, cycles at the start of each slot with all anodes off (>= 1)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  host requests a display update; accepted when load && ready
- value  in  4*DIGITS  BCD digits, digit i at bits [4i+3:4i], digit 0 rightmost
- dp_mask  in  DIGITS  decimal-point request per digit, captured with value
- ready  out  1  high when no update is pending
- digit_n  out  4  code for the external segment decoder
- an  out  DIGITS  anode enables, active-low, at most one low at any time
- dp  out  1  decimal point for the current slot, active-low
- frame_tick  out  1  one-cycle pulse at the last cycle of digit DIGITS-1's slot

## Operation
- Registers: active digits/dp (displayed), pending digits/dp (shadow), pending flag, prescaler, digit index, FSM state.
- Handshake: load && ready captures value/dp_mask into pending; ready drops on the next edge. load while ready is low is ignored (not queued).
- Commit: on the frame_tick cycle, if pending, pending → active and ready rises on that same edge. Load on the commit cycle is ignored (ready still low).
- FSM states: GUARD (an all 1s, dp=1, digit_n = active code of current index) and DRIVE (an[index]=0, dp = ~dp_mask[index]).
- GUARD → DRIVE when prescaler == GUARD-1; DRIVE → GUARD when prescaler == CLK_DIV-1, prescaler clears, index increments, wrapping DIGITS-1 → 0.
- Prescaler width $clog2(CLK_DIV); increments every cycle, never exceeds CLK_DIV-1.
- Codes 10..15 pass to the decoder unchanged (decoder shows its fault pattern); no clamping here.

## Timing
- Reset values: an all 1s, dp=1, digit_n=0, ready=1, frame_tick=0, state GUARD, index 0, prescaler 0, active and pending cleared to 0.
- Reset is applied mid-frame on the next edge: any pending update discarded, scan restarts at digit 0.
- Outputs are registered: an/dp/digit_n change one cycle after the state/prescaler condition.
- Frame period = DIGITS*CLK_DIV cycles; accepted load becomes visible at most 2 frames later, minimum at next frame boundary.
- Each anode is low for exactly CLK_DIV-GUARD consecutive cycles per frame.

## Configuration
- LEADING_ZERO_BLANK_EN defined: during DRIVE, anode of digit i (i>0) stays high if active digit i and all higher digits are 0; digit 0 always driven. Evaluated on active registers.
- Undefined: all digits driven, zeros shown.

## Structure
- Package seg_pkg: FSM state enum (ST_GUARD, ST_DRIVE), BLANK_AN constant ('1), DIGIT_W=4.
- Sub-module seg_tick_gen: prescaler with CLK_DIV/GUARD parameters, outputs guard_done and slot_end pulses; FSM, index, buffers in the top.

## Test plan
- Bench params DIGITS=4, CLK_DIV=8, GUARD=2.
- Reset then run 64 cycles -> an cycles 1110,1101,1011,0111, each low 6 cycles, 2 cycles all-1s between; frame_tick every 32 cycles; digit_n=0.
- load with value=16'h1234, dp_mask=4'b0010 -> ready low next cycle; after next frame_tick digit 0 shows 4, digit 1 shows 3 with dp=0, digit 3 shows 1; ready high.
- Second load while ready low (value=16'h9999) -> ignored; display stays 1234 after two frames.
- load asserted exactly on frame_tick cycle with pending set -> not accepted; load one cycle later -> accepted, committed at following frame.
- rst pulse mid-slot of digit 2 with pending update -> next cycle an=1111, ready=1, index 0, active=0.
- With LEADING_ZERO_BLANK_EN, value=16'h0050 -> digits 3 and 2 anodes never low, digits 1 and 0 driven.
